mul_ctrl32: RTL and testbench

MUL_CTRL32 -- requirements
Module: mul_ctrl32

---
 rtl/mul_defs_pkg.sv | 18 +
 rtl/mul_ctrl32_cla32.sv | 41 ++++
 rtl/mul_ctrl32.sv | 91 +++++++++
 tb/tb_mul_ctrl32.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mul_defs_pkg.sv
// Shared multiplier/ALU constants: FSM state codes, operand/product widths, step count.
package mul_defs_pkg;
  localparam int MUL_OP_W   = 32;
  localparam int MUL_PROD_W = 64;
  localparam int MUL_STEPS  = 32;
  localparam int MUL_CNT_W  = $clog2(MUL_STEPS);
  localparam logic [MUL_CNT_W-1:0] MUL_LAST_CNT = MUL_CNT_W'(MUL_STEPS - 1);

  localparam int ALU_W    = 32;
  localparam int CLA_GRP  = 4;
  localparam int CLA_NGRP = ALU_W / CLA_GRP;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;
endpackage

// File: rtl/mul_ctrl32_cla32.sv
// 32-bit carry-lookahead adder: 4-bit groups with in-group lookahead, group carries chained by G/P.
module cla32
  import mul_defs_pkg::*;
(
  input  logic [ALU_W-1:0] i_a,
  input  logic [ALU_W-1:0] i_b,
  input  logic             i_ci,
  output logic [ALU_W-1:0] o_sum,
  output logic             o_co
);
  logic [ALU_W-1:0]  w_g, w_p, w_c;
  logic [CLA_NGRP-1:0] w_gg, w_gp;
  logic [CLA_NGRP:0]   w_cg;

  always_comb begin
    w_g  = i_a & i_b;
    w_p  = i_a ^ i_b;
    w_c  = '0;
    w_gg = '0;
    w_gp = '0;
    w_cg = '0;
    w_cg[0] = i_ci;
    for (int k = 0; k < CLA_NGRP; k++) begin
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | ((&w_p[4*k+1 +: 3]) & w_g[4*k]);
      w_gp[k] = &w_p[4*k +: 4];
      w_cg[k+1] = w_gg[k] | (w_gp[k] & w_cg[k]);
      w_c[4*k]   = w_cg[k];
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_cg[k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_cg[k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_cg[k]);
    end
    o_sum = w_p ^ w_c;
    o_co  = w_cg[CLA_NGRP];
  end
endmodule

// File: rtl/mul_ctrl32.sv
// 32x32 unsigned shift-add multiplier; 32 EXEC steps, done one cycle after the last step.
// start ignored while busy; abort cancels EXEC; result held in its own register across aborts.
module mul_ctrl32
  import mul_defs_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [MUL_OP_W-1:0]   a,
  input  logic [MUL_OP_W-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [MUL_PROD_W-1:0] result
);
  mul_state_e r_state, w_state_nxt;

  logic [MUL_OP_W-1:0]   r_a, r_q, r_m;
  logic [MUL_CNT_W-1:0]  r_cnt;
  logic [MUL_PROD_W-1:0] r_result;

  logic [MUL_OP_W-1:0] w_addend, w_sum, w_a_step, w_q_step;
  logic                w_co, w_accept, w_last;

  assign w_addend = r_q[0] ? r_m : '0;

  cla32 u_cla (
    .i_a  (r_a),
    .i_b  (w_addend),
    .i_ci (1'b0),
    .o_sum(w_sum),
    .o_co (w_co)
  );

  // Carry-out shifts into the top of A, so the 64-bit {A,Q} never overflows.
  assign w_a_step = {w_co, w_sum[MUL_OP_W-1:1]};
  assign w_q_step = {w_sum[0], r_q[MUL_OP_W-1:1]};
  assign w_accept = start && (r_state != ST_EXEC);
  assign w_last   = (r_cnt == MUL_LAST_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (abort)       w_state_nxt = ST_IDLE;
        else if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = start ? ST_EXEC : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == ST_EXEC);
    done = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_q      <= '0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_m   <= a;
      r_q   <= b;
      r_a   <= '0;
      r_cnt <= '0;
    end else if (r_state == ST_EXEC) begin
      if (abort) begin
        r_a   <= '0;
        r_q   <= '0;
        r_cnt <= '0;
      end else begin
        r_a   <= w_a_step;
        r_q   <= w_q_step;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) r_result <= {w_a_step, w_q_step};
      end
    end
  end

  assign result = r_result;
endmodule

// File: tb/tb_mul_ctrl32.sv
// Self-checking bench for mul_ctrl32: directed corner cases plus randomized ops against a product model.
module tb_mul_ctrl32;
  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] result;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] prev_res;

  always #5 clk = ~clk;

  mul_ctrl32 dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .abort (abort),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // One operation: cycle 1 follows the accepting edge; done expected in cycle 33 unless aborted.
  task automatic op(input logic [31:0] op_a, input logic [31:0] op_b,
                    input int abort_cyc, input int restart_cyc,
                    input bit pre_acc, input bit chain,
                    input logic [31:0] na, input logic [31:0] nb);
    logic [63:0] exp_prod;
    logic        eb, ed;
    int          last;
    if (!pre_acc) begin
      @(negedge clk);
      start = 1'b1;
      abort = 1'($urandom_range(0, 1));
      a = op_a;
      b = op_b;
    end
    exp_prod = {32'h0, op_a} * {32'h0, op_b};
    last = chain ? 33 : 34;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      eb = (c <= 32) && (abort_cyc == 0 || c <= abort_cyc);
      ed = (abort_cyc == 0) && (c == 33);
      check("busy", {63'h0, busy}, {63'h0, eb});
      check("done", {63'h0, done}, {63'h0, ed});
      if (c == 33) begin
        check("result", result, (abort_cyc != 0) ? prev_res : exp_prod);
        if (abort_cyc == 0) prev_res = exp_prod;
      end
      start = (c == restart_cyc) || (chain && c == 33);
      abort = (c == abort_cyc) || (chain && c == 33 && $urandom_range(0, 1) == 1);
      a = $urandom;
      b = $urandom;
      if (chain && c == 33) begin
        a = na;
        b = nb;
      end
    end
  endtask

  initial begin
    bit          pend;
    logic [31:0] pa, pb, oa, ob, xa, xb;
    int          ac, rc;
    bit          ch;

    reset = 1'b1; start = 1'b0; abort = 1'b0; a = '0; b = '0;
    prev_res = '0;
    #1;
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_result", result, 64'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    op(32'd3, 32'd5, 0, 0, 0, 0, 0, 0);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    check("max_const", prev_res, 64'hFFFF_FFFE_0000_0001);
    op(32'h0, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
    op(32'h8000_0000, 32'd2, 0, 0, 0, 0, 0, 0);
    check("shift_const", prev_res, 64'h0000_0001_0000_0000);
    op(32'd7, 32'd9, 0, 10, 0, 0, 0, 0);
    op(32'd11, 32'd13, 16, 0, 0, 0, 0, 0);
    op(32'd21, 32'd23, 0, 0, 0, 0, 0, 0);
    op(32'd5, 32'd6, 0, 0, 0, 1, 32'd100, 32'd200);
    op(32'd100, 32'd200, 0, 0, 1, 1, 32'hFFFF_FFFF, 32'd3);
    op(32'hFFFF_FFFF, 32'd3, 0, 0, 1, 0, 0, 0);

    // Asynchronous reset in the middle of EXEC.
    @(negedge clk);
    start = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", {63'h0, busy}, 64'h0);
    check("arst_done", {63'h0, done}, 64'h0);
    check("arst_result", result, 64'h0);
    prev_res = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check("post_rst_done", {63'h0, done}, 64'h0);
      check("post_rst_busy", {63'h0, busy}, 64'h0);
    end

    // start presented on the very first edge after reset release.
    @(negedge clk);
    reset = 1'b1;
    xa = rnd_opnd();
    xb = rnd_opnd();
    start = 1'b1; a = xa; b = xb;
    @(negedge clk);
    reset = 1'b0;
    op(xa, xb, 0, 0, 1, 0, 0, 0);

    pend = 1'b0; pa = '0; pb = '0;
    for (int i = 0; i < 40; i++) begin
      oa = pend ? pa : rnd_opnd();
      ob = pend ? pb : rnd_opnd();
      ac = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 32)) : 0;
      rc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 32)) : 0;
      if (ac != 0 && rc > ac) rc = 0;
      ch = (ac == 0) && ($urandom_range(0, 3) == 0) && (i < 39);
      xa = rnd_opnd();
      xb = rnd_opnd();
      op(oa, ob, ac, rc, pend, ch, xa, xb);
      pend = ch; pa = xa; pb = xb;
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
